// File: rtl/sccb_config_seq.sv
// sccb_config_seq
//   Walks a synchronous config ROM of {reg_addr, value} words and issues one SCCB
//   write per entry through the controller's start/done handshake. 16'hFFFF ends
//   the table, 16'hFFF0 inserts a DELAY_MS wait. A NACKed write is retried up to
//   MAX_RETRY attempts in total, then the pass aborts with error_o.
// Ports
//   clk_i, rst_i           clock, async active-low reset
//   go_i                   start a pass from ROM address 0 (ignored while busy)
//   rom_addr_o/rom_data_i  config ROM, data valid one cycle after the address
//   sccb_*                 controller request: device id, {reg,val}, rw, start/done/nack
//   busy_o/done_o/error_o  pass status; done/error sticky until the next go_i
//   reg_count_o            successful writes this pass (saturating)
module sccb_config_seq #(
    parameter int          ADDR_W     = 6,
    parameter logic [7:0]  DEVICE_ID  = 8'h42,
    parameter int          MAX_RETRY  = 3,
    parameter int          CLK_PER_MS = 50000,
    parameter int          DELAY_MS   = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              go_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic [7:0]        sccb_addr_o,
    output logic [15:0]       sccb_data_o,
    output logic              sccb_rw_o,
    output logic              sccb_start_o,
    input  logic              sccb_done_i,
    input  logic              sccb_ack_error_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W-1:0] reg_count_o
);
    localparam int DLY_CYC = DELAY_MS * CLK_PER_MS;
    localparam int DLY_W   = (DLY_CYC > 1) ? $clog2(DLY_CYC) : 1;
    localparam int RTY_W   = $clog2(MAX_RETRY + 1);
    localparam logic [DLY_W-1:0]  DLY_LOAD = DLY_W'(DLY_CYC - 1);
    localparam logic [RTY_W-1:0]  RTY_LAST = RTY_W'(MAX_RETRY);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_START, S_WAIT_DONE,
        S_WAIT_CLR, S_DELAY, S_NEXT, S_FINISH, S_FAIL
    } state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [15:0]       r_data;
    logic              r_done, r_err, r_nack;
    logic [ADDR_W-1:0] r_cnt;
    logic [RTY_W-1:0]  r_retry;
    logic [DLY_W-1:0]  r_dly;
    logic [RTY_W-1:0]  w_retry_inc;

    assign w_retry_inc = r_retry + 1'b1;

    // state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (go_i) w_next = S_FETCH;
            S_FETCH:     w_next = S_DECODE;
            S_DECODE: begin
                if (rom_data_i == 16'hFFFF)      w_next = S_FINISH;
                else if (rom_data_i == 16'hFFF0) w_next = S_DELAY;
                else                             w_next = S_START;
            end
            S_START:     w_next = S_WAIT_DONE;
            S_WAIT_DONE: if (sccb_done_i) w_next = S_WAIT_CLR;
            S_WAIT_CLR: begin
                // only re-request once the controller has dropped done
                if (!sccb_done_i) begin
                    if (!r_nack)                  w_next = S_NEXT;
                    else if (w_retry_inc == RTY_LAST) w_next = S_FAIL;
                    else                          w_next = S_START;
                end
            end
            S_DELAY:     if (r_dly == '0) w_next = S_NEXT;
            S_NEXT:      w_next = (r_rom_addr == ADDR_MAX) ? S_FINISH : S_FETCH;
            S_FINISH:    w_next = S_IDLE;
            S_FAIL:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // datapath registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rom_addr <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_nack     <= 1'b0;
            r_cnt      <= '0;
            r_retry    <= '0;
            r_dly      <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (go_i) begin
                    r_rom_addr <= '0;
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                    r_cnt      <= '0;
                    r_retry    <= '0;
                end
                S_DECODE: begin
                    if (rom_data_i == 16'hFFF0)      r_dly  <= DLY_LOAD;
                    else if (rom_data_i != 16'hFFFF) r_data <= rom_data_i;
                end
                S_WAIT_DONE: if (sccb_done_i) r_nack <= sccb_ack_error_i;
                S_WAIT_CLR: if (!sccb_done_i) begin
                    if (!r_nack) begin
                        r_retry <= '0;
                        if (r_cnt != ADDR_MAX) r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_retry <= w_retry_inc;
                    end
                end
                S_DELAY:  if (r_dly != '0) r_dly <= r_dly - 1'b1;
                S_NEXT:   if (r_rom_addr != ADDR_MAX) r_rom_addr <= r_rom_addr + 1'b1;
                S_FINISH: r_done <= 1'b1;
                S_FAIL:   r_err  <= 1'b1;
                default: ;
            endcase
        end
    end

    // outputs decoded from state so reset drops start in the same cycle
    always_comb begin
        sccb_start_o = (r_state == S_START) || (r_state == S_WAIT_DONE);
        busy_o       = !((r_state == S_IDLE) || (r_state == S_FINISH) || (r_state == S_FAIL));
    end

    assign rom_addr_o  = r_rom_addr;
    assign sccb_addr_o = DEVICE_ID;
    assign sccb_data_o = r_data;
    assign sccb_rw_o   = 1'b1;
    assign done_o      = r_done;
    assign error_o     = r_err;
    assign reg_count_o = r_cnt;

endmodule

// File: tb/tb_sccb_config_seq.sv
// Bench for sccb_config_seq: 4-entry ROM, 2 ms delay at 10 clk/ms, MAX_RETRY=3.
// A behavioural SCCB controller answers start with done after a programmable
// latency, NACKing the first N transactions (or all of them) of a pass.
module tb_sccb_config_seq;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        go_i  = 1'b0;
    logic [1:0]  rom_addr_o;
    logic [15:0] rom_data_i;
    logic [7:0]  sccb_addr_o;
    logic [15:0] sccb_data_o;
    logic        sccb_rw_o, sccb_start_o;
    logic        sccb_done_i, sccb_ack_error_i;
    logic        busy_o, done_o, error_o;
    logic [1:0]  reg_count_o;

    sccb_config_seq #(.ADDR_W(2), .DEVICE_ID(8'h42), .MAX_RETRY(3),
                      .CLK_PER_MS(10), .DELAY_MS(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .go_i(go_i),
        .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .sccb_addr_o(sccb_addr_o), .sccb_data_o(sccb_data_o),
        .sccb_rw_o(sccb_rw_o), .sccb_start_o(sccb_start_o),
        .sccb_done_i(sccb_done_i), .sccb_ack_error_i(sccb_ack_error_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .reg_count_o(reg_count_o));

    always #5 clk_i = ~clk_i;

    // synchronous config ROM
    logic [15:0] rom [4];
    always @(posedge clk_i) rom_data_i <= rom[rom_addr_o];

    // controller model
    int          m_lat = 2;
    int          nack_budget = 0;
    bit          nack_all = 1'b0;
    int          base_txn = 0;
    int          txn_cnt = 0;
    int          viol = 0;
    int          m_st, m_cnt;
    logic [15:0] log_mem [32];

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_st <= 0; m_cnt <= 0;
            sccb_done_i <= 1'b0; sccb_ack_error_i <= 1'b0;
        end else begin
            case (m_st)
                0: if (sccb_start_o) begin
                    log_mem[txn_cnt % 32] <= sccb_data_o;
                    txn_cnt <= txn_cnt + 1;
                    m_cnt   <= m_lat;
                    m_st    <= 1;
                end
                1: if (!sccb_start_o) m_st <= 0;
                   else if (m_cnt == 0) begin
                       sccb_done_i      <= 1'b1;
                       sccb_ack_error_i <= nack_all || ((txn_cnt - base_txn) <= nack_budget);
                       m_st <= 2;
                   end else m_cnt <= m_cnt - 1;
                2: if (!sccb_start_o) m_st <= 3;
                default: begin
                    // done still high here: start must not be back yet
                    if (sccb_start_o) viol <= viol + 1;
                    sccb_done_i <= 1'b0; sccb_ack_error_i <= 1'b0;
                    m_st <= 0;
                end
            endcase
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] r0, r1, r2, r3;
        int          nacks;
        bit          all;
        int          txn;
        bit          done;
        bit          err;
        int          cnt;
        int          addr;
        int          lat;   // cycles from go to first start, 0 = never
        logic [15:0] first, last;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] r0, r1, r2, r3, input int nacks,
                                input bit all, input int txn, input bit d, input bit e,
                                input int cnt, input int addr, input int lat,
                                input logic [15:0] f, l);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.r2 = r2; v.r3 = r3;
        v.nacks = nacks; v.all = all; v.txn = txn; v.done = d; v.err = e;
        v.cnt = cnt; v.addr = addr; v.lat = lat; v.first = f; v.last = l;
        return v;
    endfunction

    task automatic pulse_go();
        @(negedge clk_i); go_i = 1'b1;
        @(negedge clk_i); go_i = 1'b0;
    endtask

    task automatic wait_end(input string name, output int lat);
        int cyc;
        lat = 0; cyc = 1;
        while (!(done_o || error_o) && cyc < 400) begin
            if (sccb_start_o && lat == 0) lat = cyc;
            @(negedge clk_i); cyc++;
        end
        if (!(done_o || error_o)) chk({name, " timeout"}, 0, 1);
    endtask

    vec_t vecs [9];

    initial begin
        int lat, n, k;
        string nm;

        vecs[0] = mk(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF, 0, 0, 2, 1, 0, 2, 2, 3,  16'h1280, 16'h1101);
        vecs[1] = mk(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2, 0, 3, 1, 0, 1, 1, 3,  16'h1280, 16'h1280);
        vecs[2] = mk(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 1, 3, 0, 1, 0, 0, 3,  16'h1280, 16'h1280);
        vecs[3] = mk(16'hFFF0, 16'h1101, 16'hFFFF, 16'hFFFF, 0, 0, 1, 1, 0, 1, 2, 26, 16'h1101, 16'h1101);
        vecs[4] = mk(16'h0A55, 16'h0A55, 16'h0A55, 16'h0A55, 0, 0, 4, 1, 0, 3, 3, 3,  16'h0A55, 16'h0A55);
        vecs[5] = mk(16'h1101, 16'h1101, 16'h1101, 16'hFFF0, 0, 0, 3, 1, 0, 3, 3, 3,  16'h1101, 16'h1101);
        vecs[6] = mk(16'hFFFF, 16'h1101, 16'hFFFF, 16'hFFFF, 0, 0, 0, 1, 0, 0, 0, 0,  16'h0000, 16'h0000);
        vecs[7] = mk(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF, 2, 0, 4, 1, 0, 2, 2, 3,  16'h1280, 16'h1101);
        vecs[8] = mk(16'h0A55, 16'hFFF0, 16'hFFFF, 16'hFFFF, 0, 0, 1, 1, 0, 1, 2, 3,  16'h0A55, 16'h0A55);

        rom[0] = 16'h1280; rom[1] = 16'hFFFF; rom[2] = 16'hFFFF; rom[3] = 16'hFFFF;
        repeat (3) @(negedge clk_i);

        // reset state
        chk("rst rom_addr", rom_addr_o, 0);
        chk("rst data", sccb_data_o, 0);
        chk("rst start", sccb_start_o, 0);
        chk("rst busy/done/err", {busy_o, done_o, error_o}, 0);
        chk("rst reg_count", reg_count_o, 0);
        chk("sccb_addr", sccb_addr_o, 8'h42);
        chk("sccb_rw", sccb_rw_o, 1);
        rst_i = 1'b1;

        // reset asserted while waiting on a slow controller
        m_lat = 20; base_txn = txn_cnt;
        pulse_go();
        n = 0;
        while (!sccb_start_o && n < 50) begin @(negedge clk_i); n++; end
        chk("mid start seen", sccb_start_o, 1);
        repeat (3) @(negedge clk_i);
        chk("mid still waiting", {sccb_start_o, busy_o}, 2'b11);
        rst_i = 1'b0; #1;
        chk("mid rst start drop", sccb_start_o, 0);
        chk("mid rst outputs", {busy_o, done_o, error_o, rom_addr_o, reg_count_o}, 0);
        chk("mid rst data", sccb_data_o, 0);
        @(negedge clk_i); rst_i = 1'b1; m_lat = 2;

        // table-driven passes
        foreach (vecs[i]) begin
            nm = $sformatf("v%0d", i);
            rom[0] = vecs[i].r0; rom[1] = vecs[i].r1; rom[2] = vecs[i].r2; rom[3] = vecs[i].r3;
            nack_budget = vecs[i].nacks; nack_all = vecs[i].all;
            base_txn = txn_cnt;
            pulse_go();
            chk({nm, " after go busy/done/err"}, {busy_o, done_o, error_o}, 3'b100);
            wait_end(nm, lat);
            @(negedge clk_i);
            n = txn_cnt - base_txn;
            chk({nm, " txns"}, n, vecs[i].txn);
            chk({nm, " done"}, done_o, vecs[i].done);
            chk({nm, " error"}, error_o, vecs[i].err);
            chk({nm, " reg_count"}, reg_count_o, vecs[i].cnt);
            chk({nm, " rom_addr"}, rom_addr_o, vecs[i].addr);
            chk({nm, " start latency"}, lat, vecs[i].lat);
            chk({nm, " busy end"}, {busy_o, sccb_start_o}, 0);
            if (vecs[i].txn > 0) begin
                k = base_txn % 32;
                chk({nm, " first data"}, log_mem[k], vecs[i].first);
                k = (txn_cnt - 1) % 32;
                chk({nm, " last data"}, log_mem[k], vecs[i].last);
            end
        end

        // go while busy must not restart the pass
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF; rom[3] = 16'hFFFF;
        nack_budget = 0; nack_all = 1'b0; base_txn = txn_cnt;
        pulse_go();
        n = 0;
        while ((txn_cnt - base_txn) < 2 && n < 200) begin @(negedge clk_i); n++; end
        chk("busy go reached 2nd", rom_addr_o, 1);
        pulse_go();
        wait_end("busy go", lat);
        @(negedge clk_i);
        chk("busy go txns", txn_cnt - base_txn, 2);
        chk("busy go reg_count", reg_count_o, 2);
        chk("busy go done", {done_o, error_o}, 2'b10);
        k = (txn_cnt - 1) % 32;
        chk("busy go last data", log_mem[k], 16'h1101);

        chk("start reasserted under done", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
